// File: rtl/mxint_accum_pkg.sv
// Shared sizing helpers for the MxInt multichannel accumulator.
// Bias and padding widths derive from the MxInt parameters.
package mxint_accum_pkg;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int cnt_w(input int max_depth);
        return $clog2(max_depth) + 1;
    endfunction

    function automatic int exp_bias(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int left_pad(input int max_depth);
        return $clog2(max_depth);
    endfunction

    function automatic int right_pad(input int p1);
        return 1 << p1;
    endfunction

endpackage

// File: rtl/mxint_block_align_add.sv
// Aligns one MxInt block to a running accumulator and adds it.
// The larger exponent wins; the other operand is shifted right.
module mxint_block_align_add
    import mxint_accum_pkg::*;
#(
    parameter int P0         = 8,
    parameter int P1         = 4,
    parameter int BLOCK_SIZE = 4,
    parameter int MAX_DEPTH  = 4,
    parameter int OUT_P0     = 26
) (
    input  logic              empty,
    input  logic [OUT_P0-1:0] acc      [BLOCK_SIZE],
    input  logic [P1-1:0]     max_e,
    input  logic [P0-1:0]     m_in     [BLOCK_SIZE],
    input  logic [P1-1:0]     e_in,
    output logic [OUT_P0-1:0] acc_next [BLOCK_SIZE],
    output logic [P1-1:0]     max_next
);
    localparam int LEFT  = left_pad(MAX_DEPTH);
    localparam int RIGHT = right_pad(P1);

    // Shifting past the full width leaves only sign bits.
    function automatic logic [OUT_P0-1:0] asr(
        input logic [OUT_P0-1:0] x,
        input logic [P1-1:0]     sh
    );
        if (int'(sh) >= OUT_P0)
            return {OUT_P0{x[OUT_P0-1]}};
        return $signed(x) >>> sh;
    endfunction

    logic          up;
    logic [P1-1:0] d_up;
    logic [P1-1:0] d_dn;

    assign up       = e_in > max_e;
    assign d_up     = e_in - max_e;
    assign d_dn     = max_e - e_in;
    assign max_next = (empty || up) ? e_in : max_e;

    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
        logic [OUT_P0-1:0] padded;
        assign padded = {{LEFT{m_in[i][P0-1]}}, m_in[i], {RIGHT{1'b0}}};
        assign acc_next[i] = empty ? padded :
                             up    ? asr(acc[i], d_up) + padded :
                                     acc[i] + asr(padded, d_dn);
    end

endmodule

// File: rtl/mxint_multichannel_accumulator.sv
// Per-channel MxInt block accumulator with a single registered output.
// A beat closes its channel on last or when the depth limit is reached.
module mxint_multichannel_accumulator
    import mxint_accum_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 4,
    parameter int BLOCK_SIZE             = 4,
    parameter int MAX_DEPTH              = 4,
    parameter int NUM_CH                 = 2,
    parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0
        + 2 ** DATA_IN_0_PRECISION_1 + $clog2(MAX_DEPTH),
    parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1
        + $clog2($clog2(MAX_DEPTH) + 1),
    localparam int CH_W  = ch_w(NUM_CH),
    localparam int CNT_W = cnt_w(MAX_DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  mdata_in_0 [BLOCK_SIZE],
    input  logic [DATA_IN_0_PRECISION_1-1:0]  edata_in_0,
    input  logic [CH_W-1:0]                   data_in_0_ch,
    input  logic                              data_in_0_last,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE],
    output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
    output logic [CH_W-1:0]                   data_out_0_ch,
    output logic [CNT_W-1:0]                  data_out_0_count,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              err_ch
);
    localparam int P0      = DATA_IN_0_PRECISION_0;
    localparam int P1      = DATA_IN_0_PRECISION_1;
    localparam int OUT_P0  = DATA_OUT_0_PRECISION_0;
    localparam int OUT_P1  = DATA_OUT_0_PRECISION_1;
    localparam int EXP_ADJ = exp_bias(OUT_P1) - exp_bias(P1)
                           + left_pad(MAX_DEPTH);

    logic [OUT_P0-1:0] acc_q [NUM_CH][BLOCK_SIZE];
    logic [P1-1:0]     max_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    logic              ch_ok;
    logic              accept;
    logic              hit;
    logic              empty;
    logic              close;
    logic [CH_W-1:0]   sel;
    logic [CNT_W-1:0]  cnt_next;
    logic [OUT_P0-1:0] acc_next [BLOCK_SIZE];
    logic [P1-1:0]     max_next;

    assign data_in_0_ready = !data_out_0_valid || data_out_0_ready;
    assign accept   = data_in_0_valid && data_in_0_ready;
    assign ch_ok    = int'(data_in_0_ch) < NUM_CH;
    assign hit      = accept && ch_ok;
    // Out-of-range channels alias onto channel 0 but never write it.
    assign sel      = ch_ok ? data_in_0_ch : '0;
    assign empty    = cnt_q[sel] == '0;
    assign cnt_next = empty ? CNT_W'(1) : cnt_q[sel] + CNT_W'(1);
    assign close    = hit && (data_in_0_last
                   || cnt_next == CNT_W'(MAX_DEPTH));

    mxint_block_align_add #(
        .P0         (P0),
        .P1         (P1),
        .BLOCK_SIZE (BLOCK_SIZE),
        .MAX_DEPTH  (MAX_DEPTH),
        .OUT_P0     (OUT_P0)
    ) u_align_add (
        .empty    (empty),
        .acc      (acc_q[sel]),
        .max_e    (max_q[sel]),
        .m_in     (mdata_in_0),
        .e_in     (edata_in_0),
        .acc_next (acc_next),
        .max_next (max_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                max_q[c] <= '0;
                for (int b = 0; b < BLOCK_SIZE; b++)
                    acc_q[c][b] <= '0;
            end
            for (int b = 0; b < BLOCK_SIZE; b++)
                mdata_out_0[b] <= '0;
            edata_out_0      <= '0;
            data_out_0_ch    <= '0;
            data_out_0_count <= '0;
            data_out_0_valid <= 1'b0;
            err_ch           <= 1'b0;
        end else begin
            if (hit) begin
                cnt_q[sel] <= close ? '0 : cnt_next;
                max_q[sel] <= max_next;
                acc_q[sel] <= acc_next;
            end
            if (accept && !ch_ok)
                err_ch <= 1'b1;
            if (close) begin
                mdata_out_0      <= acc_next;
                edata_out_0      <= OUT_P1'(max_next) + OUT_P1'(EXP_ADJ);
                data_out_0_ch    <= sel;
                data_out_0_count <= cnt_next;
                data_out_0_valid <= 1'b1;
            end else if (data_out_0_ready) begin
                data_out_0_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mxint_multichannel_accumulator.sv
// Directed bench for the MxInt multichannel accumulator.
// Table of beats with hand-computed results plus corner sequences.
module tb_mxint_multichannel_accumulator;

    localparam int BS = 4;

    typedef struct {
        int         ch;
        logic [7:0] m;
        logic [3:0] e;
        bit         last;
        bit         xv;
        int         xch;
        logic [25:0] xm;
        int         xe;
        int         xc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  m_in [BS];
    logic [3:0]  e_in = '0;
    logic        ch_in = 1'b0;
    logic        last_in = 1'b0;
    logic        v_in = 1'b0;
    logic        rdy_in;
    logic [25:0] m_out [BS];
    logic [5:0]  e_out;
    logic        ch_out;
    logic [2:0]  cnt_out;
    logic        v_out;
    logic        rdy_out = 1'b1;
    logic        err;

    logic [1:0]  ch3_in = '0;
    logic        v3_in = 1'b0;
    logic        rdy3_in;
    logic [25:0] m3_out [BS];
    logic [5:0]  e3_out;
    logic [1:0]  ch3_out;
    logic [2:0]  cnt3_out;
    logic        v3_out;
    logic        err3;

    int n_run  = 0;
    int n_fail = 0;
    vec_t vecs [$];

    always #5 clk = ~clk;

    mxint_multichannel_accumulator u_dut (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (m_in),
        .edata_in_0       (e_in),
        .data_in_0_ch     (ch_in),
        .data_in_0_last   (last_in),
        .data_in_0_valid  (v_in),
        .data_in_0_ready  (rdy_in),
        .mdata_out_0      (m_out),
        .edata_out_0      (e_out),
        .data_out_0_ch    (ch_out),
        .data_out_0_count (cnt_out),
        .data_out_0_valid (v_out),
        .data_out_0_ready (rdy_out),
        .err_ch           (err)
    );

    mxint_multichannel_accumulator #(.NUM_CH(3)) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (m_in),
        .edata_in_0       (e_in),
        .data_in_0_ch     (ch3_in),
        .data_in_0_last   (last_in),
        .data_in_0_valid  (v3_in),
        .data_in_0_ready  (rdy3_in),
        .mdata_out_0      (m3_out),
        .edata_out_0      (e3_out),
        .data_out_0_ch    (ch3_out),
        .data_out_0_count (cnt3_out),
        .data_out_0_valid (v3_out),
        .data_out_0_ready (1'b1),
        .err_ch           (err3)
    );

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic chk_lanes(input string name, input logic [25:0] exp);
        bit ok = 1'b1;
        for (int i = 0; i < BS; i++)
            if (m_out[i] !== exp) ok = 1'b0;
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: lanes %0h %0h %0h %0h expected 0x%0h",
                     name, m_out[0], m_out[1], m_out[2], m_out[3], exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int ch, input logic [7:0] m,
                        input logic [3:0] e, input bit last);
        ch_in   = ch[0];
        for (int i = 0; i < BS; i++) m_in[i] = m;
        e_in    = e;
        last_in = last;
        v_in    = 1'b1;
    endtask

    task automatic add(input int ch, input logic [7:0] m,
                       input logic [3:0] e, input bit last,
                       input bit xv, input int xch,
                       input logic [25:0] xm, input int xe, input int xc);
        vec_t v;
        v.ch = ch; v.m = m; v.e = e; v.last = last;
        v.xv = xv; v.xch = xch; v.xm = xm; v.xe = xe; v.xc = xc;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < BS; i++) m_in[i] = '0;

        add(0, 8'd1,   4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(0, 8'd1,   4'd7,  1, 1, 0, 26'h20000,   33, 2);
        add(0, 8'd4,   4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(0, 8'd4,   4'd8,  1, 1, 0, 26'h60000,   34, 2);
        add(1, 8'd1,   4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(1, 8'd1,   4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(1, 8'd1,   4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(1, 8'd1,   4'd7,  0, 1, 1, 26'h40000,   33, 4);
        add(0, 8'hFE,  4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(0, 8'd1,   4'd9,  1, 1, 0, 26'h8000,    35, 2);
        add(1, 8'd1,   4'd0,  0, 0, 0, 26'h0,       0,  0);
        add(1, 8'd1,   4'd15, 1, 1, 1, 26'h10002,   41, 2);
        add(0, 8'hFF,  4'd15, 0, 0, 0, 26'h0,       0,  0);
        add(0, 8'h80,  4'd0,  1, 1, 0, 26'h3FEFF00, 41, 2);
        add(0, 8'd2,   4'd7,  0, 0, 0, 26'h0,       0,  0);
        add(1, 8'd3,   4'd9,  0, 0, 0, 26'h0,       0,  0);
        add(0, 8'd2,   4'd8,  1, 1, 0, 26'h30000,   34, 2);
        add(1, 8'd1,   4'd8,  1, 1, 1, 26'h38000,   35, 2);

        step();
        step();
        rst = 1'b0;
        chk("rst_valid", v_out, 0);
        chk_lanes("rst_mant", 26'h0);
        chk("rst_edata", e_out, 0);
        chk("rst_ch", ch_out, 0);
        chk("rst_count", cnt_out, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", rdy_in, 1);

        foreach (vecs[k]) begin
            beat(vecs[k].ch, vecs[k].m, vecs[k].e, vecs[k].last);
            step();
            chk($sformatf("v%0d_valid", k), v_out, vecs[k].xv);
            if (vecs[k].xv) begin
                chk_lanes($sformatf("v%0d_mant", k), vecs[k].xm);
                chk($sformatf("v%0d_edata", k), e_out, vecs[k].xe);
                chk($sformatf("v%0d_ch", k), ch_out, vecs[k].xch);
                chk($sformatf("v%0d_count", k), cnt_out, vecs[k].xc);
            end
        end
        v_in = 1'b0;
        step();
        chk("drain_valid", v_out, 0);

        rdy_out = 1'b0;
        beat(0, 8'd1, 4'd7, 1);
        step();
        chk("bp_valid", v_out, 1);
        chk_lanes("bp_mant", 26'h10000);
        chk("bp_count", cnt_out, 1);
        beat(1, 8'd5, 4'd7, 1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_in_ready%0d", c), rdy_in, 0);
            chk($sformatf("bp_hold_valid%0d", c), v_out, 1);
            chk_lanes($sformatf("bp_hold_mant%0d", c), 26'h10000);
            chk($sformatf("bp_hold_ch%0d", c), ch_out, 0);
        end
        rdy_out = 1'b1;
        step();
        v_in = 1'b0;
        chk("b2b_valid", v_out, 1);
        chk_lanes("b2b_mant", 26'h50000);
        chk("b2b_ch", ch_out, 1);
        chk("b2b_edata", e_out, 33);
        step();
        chk("b2b_drop", v_out, 0);

        ch3_in = 2'd3;
        for (int i = 0; i < BS; i++) m_in[i] = 8'd1;
        e_in = 4'd7;
        last_in = 1'b1;
        v3_in = 1'b1;
        step();
        v3_in = 1'b0;
        chk("err_set", err3, 1);
        chk("err_no_out", v3_out, 0);
        step();
        chk("err_sticky", err3, 1);
        chk("err_no_out2", v3_out, 0);

        rdy_out = 1'b0;
        beat(0, 8'd1, 4'd7, 0);
        step();
        beat(1, 8'd1, 4'd7, 1);
        step();
        v_in = 1'b0;
        chk("pre_rst_pending", v_out, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdy_out = 1'b1;
        chk("mid_rst_valid", v_out, 0);
        chk("mid_rst_err", err3, 0);
        step();
        chk("mid_rst_quiet", v_out, 0);
        beat(0, 8'd2, 4'd7, 1);
        step();
        v_in = 1'b0;
        chk("post_rst_valid", v_out, 1);
        chk_lanes("post_rst_mant", 26'h20000);
        chk("post_rst_count", cnt_out, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mxint_multichannel_accumulator.md
MXINT_MULTICHANNEL_ACCUMULATOR -- requirements
Module: mxint_multichannel_accumulator

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8: input mantissa width.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 4: input exponent width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 4: mantissas per MxInt block.
REQ-004 SHALL have parameter MAX_DEPTH, default 4: maximum number of beats per accumulation, at least 2.
REQ-005 SHALL have parameter NUM_CH, default 2: number of independent accumulation channels, at least 1.
REQ-006 SHALL have parameter DATA_OUT_0_PRECISION_0, default P0 + 2**P1 + clog2(MAX_DEPTH): output mantissa width.
REQ-007 SHALL have parameter DATA_OUT_0_PRECISION_1, default P1 + clog2(clog2(MAX_DEPTH)+1): output exponent width.
REQ-008 SHALL have local constants CH_W = max(1, clog2(NUM_CH)) and CNT_W = clog2(MAX_DEPTH)+1.
REQ-009 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, reset synchronous and active-high.
REQ-010 SHALL have ports mdata_in_0 (in, [BLOCK_SIZE] x P0, signed mantissas) and edata_in_0 (in, P1, biased exponent).
REQ-011 SHALL have ports data_in_0_ch (in, CH_W, channel), data_in_0_last (in, 1, closes the accumulation), data_in_0_valid (in, 1) and data_in_0_ready (out, 1).
REQ-012 SHALL have ports mdata_out_0 (out, [BLOCK_SIZE] x OUT_P0) and edata_out_0 (out, OUT_P1).
REQ-013 SHALL have ports data_out_0_ch (out, CH_W), data_out_0_count (out, CNT_W, beats summed), data_out_0_valid (out, 1) and data_out_0_ready (in, 1).
REQ-014 SHALL have port err_ch (out, 1): sticky flag, set when a beat arrives on an out-of-range channel.

Function
REQ-015 SHALL keep per-channel state: mantissa accumulator [BLOCK_SIZE] x OUT_P0, max exponent (P1 bits) and beat count (CNT_W bits); count 0 means the channel is empty.
REQ-016 SHALL drive data_in_0_ready = !data_out_0_valid || data_out_0_ready, which applies to all beats.
REQ-017 SHALL treat a beat as accepted when data_in_0_valid && data_in_0_ready.
REQ-018 SHALL form the padded input as: LEFT = clog2(MAX_DEPTH) sign bits, then the mantissa, then RIGHT = 2**P1 zero bits.
REQ-019 SHALL, on an accepted beat to an empty channel, load the padded input, set max = edata_in_0 and set count = 1.
REQ-020 SHALL, on an accepted beat to a non-empty channel with edata_in_0 <= max, set acc = acc + (padded >>> (max - e_in)).
REQ-021 SHALL, on an accepted beat to a non-empty channel with edata_in_0 > max, set acc = (acc >>> (e_in - max)) + padded and max = e_in.
REQ-022 SHALL use arithmetic right shifts in REQ-020/021; a shift of OUT_P0 or more yields all sign bits.
REQ-023 SHALL increment count on every accepted beat to a non-empty channel.
REQ-024 SHALL treat a beat as closing when data_in_0_last = 1 or the post-update count equals MAX_DEPTH (forced close).
REQ-025 SHALL, on a closing beat, load the output register in the next cycle and raise data_out_0_valid; latency is 1 cycle.
REQ-026 SHALL load the output register with the post-update accumulator, edata_out_0 = max - EXP_IN_BIAS + EXP_OUT_BIAS + LEFT, the channel and the count.
REQ-027 SHALL clear the closing channel to empty in the same cycle.
REQ-028 SHALL hold the output register stable while data_out_0_valid && !data_out_0_ready.
REQ-029 SHALL allow a new closing beat to reload the output register in the cycle the old result is consumed.
REQ-030 SHALL drop data_out_0_valid after a consume with no new close.
REQ-031 SHALL accept and discard a beat with data_in_0_ch >= NUM_CH, set err_ch and leave all channel state unchanged.
REQ-032 SHALL leave non-addressed channels untouched on every beat.
REQ-033 SHALL use biases EXP_IN_BIAS = 2**(P1-1)-1 and EXP_OUT_BIAS = 2**(OUT_P1-1)-1.

Reset
REQ-034 SHALL, on rst, empty all channels and drive data_out_0_valid = 0, mdata_out_0 = 0, edata_out_0 = 0, data_out_0_ch = 0, data_out_0_count = 0 and err_ch = 0.
REQ-035 SHALL, on rst mid-accumulation or with an output pending, discard the partial sums and the pending output without emitting them.

Structure
REQ-036 SHALL place the bias and padding constants and the CH_W and CNT_W functions in package mxint_accum_pkg.
REQ-037 SHALL implement the per-block align-and-add (REQ-019..022) in combinational sub-module mxint_block_align_add, instantiated once for the addressed channel.

Verification (P0=8, P1=4, BLOCK_SIZE=4, MAX_DEPTH=4, NUM_CH=2; so OUT_P0=26, OUT_P1=6)
REQ-038 SHALL check: ch0 beats (m=1, e=7), then (m=1, e=7, last) -> 1 cycle later mant = 0x20000 in all lanes, edata = 33, count = 2, ch = 0.
REQ-039 SHALL check: ch0 beats (m=4, e=7), then (m=4, e=8, last) -> mant = 0x60000, edata = 34.
REQ-040 SHALL check: ch1 sends 4 beats (m=1, e=7) with no last -> forced close, count = 4, mant = 0x40000.
REQ-041 SHALL check: ch0 and ch1 beats interleaved with different exponents -> two outputs, each equal to its own isolated sum, in closing order.
REQ-042 SHALL check: data_out_0_ready held low for 5 cycles with an output pending -> data_in_0_ready = 0 and the output is stable; on release the next close is loaded back-to-back.
REQ-043 SHALL check: beat on ch = 3 (with CH_W widened via NUM_CH=3, sending ch = 3) -> err_ch = 1 and no output; rst asserted mid-accumulation -> no output and err_ch = 0.
